hazard_scoreboard: RTL

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_scoreboard.sv | 134 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// Stall and forwarding control for a 5-stage pipeline with Tnew/Tuse
// bookkeeping per stage and a HI/LO busy counter.
module hazard_scoreboard #(
   parameter int ADDR_W   = 5,
   parameter int TNEW_W   = 2,
   parameter int MULT_CYC = 5,
   parameter int DIV_CYC  = 10,
   parameter int CNT_W    = 4
)(
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rs_d,
   input  logic [ADDR_W-1:0] rt_d,
   input  logic [TNEW_W-1:0] tuse_rs,
   input  logic [TNEW_W-1:0] tuse_rt,
   input  logic [ADDR_W-1:0] a3_d,
   input  logic              we_d,
   input  logic [TNEW_W-1:0] tnew_d,
   input  logic              md_use_d,
   input  logic              md_start_d,
   input  logic              md_div_d,
   output logic              stall,
   output logic [1:0]        rs_fwd_d,
   output logic [1:0]        rt_fwd_d,
   output logic [1:0]        rs_fwd_e,
   output logic [1:0]        rt_fwd_e,
   output logic              rt_fwd_m,
   output logic              md_busy
);

   typedef logic [ADDR_W-1:0] reg_t;
   typedef logic [TNEW_W-1:0] tn_t;

   typedef struct packed {
      reg_t a3;
      logic we;
      tn_t  tnew;
      reg_t rs;
      reg_t rt;
   } rec_t;

   typedef struct packed {
      reg_t a3;
      logic we;
      tn_t  tnew;
   } wrec_t;

   rec_t             e_q, e_d, m_q, m_d;
   wrec_t            w_q, w_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             hz_rs, hz_rt;

   function automatic logic hit(reg_t r, reg_t a3, logic we);
      return (r != '0) && we && (a3 == r);
   endfunction

   function automatic tn_t dec(tn_t t);
      return (t == '0) ? '0 : t - 1'b1;
   endfunction

   // Only the youngest writer of r is relevant; older ones hold stale data.
   function automatic logic [2:0] dsrc(reg_t r, tn_t tuse,
                                       rec_t e, rec_t m, wrec_t w);
      logic [1:0] sel;
      tn_t        tn;
      sel = 2'd0;
      tn  = '0;
      if (hit(r, e.a3, e.we)) begin
         tn  = e.tnew;
         sel = 2'd3;
      end else if (hit(r, m.a3, m.we)) begin
         tn  = m.tnew;
         sel = 2'd2;
      end else if (hit(r, w.a3, w.we)) begin
         tn  = w.tnew;
         sel = 2'd1;
      end
      if (tn != '0) sel = 2'd0;
      return {tn > tuse, sel};
   endfunction

   function automatic logic [1:0] esrc(reg_t r, rec_t m, wrec_t w);
      if (hit(r, m.a3, m.we) && m.tnew == '0) return 2'd2;
      if (hit(r, w.a3, w.we) && w.tnew == '0) return 2'd1;
      return 2'd0;
   endfunction

   always_comb begin
      {hz_rs, rs_fwd_d} = dsrc(rs_d, tuse_rs, e_q, m_q, w_q);
      {hz_rt, rt_fwd_d} = dsrc(rt_d, tuse_rt, e_q, m_q, w_q);
      rs_fwd_e = esrc(e_q.rs, m_q, w_q);
      rt_fwd_e = esrc(e_q.rt, m_q, w_q);
      rt_fwd_m = hit(m_q.rt, w_q.a3, w_q.we);
      md_busy  = (cnt_q != '0);
      stall    = hz_rs | hz_rt | (md_use_d & md_busy);
   end

   always_comb begin
      e_d = '0;
      if (!stall) begin
         e_d.a3   = a3_d;
         e_d.we   = we_d;
         e_d.tnew = tnew_d;
         e_d.rs   = rs_d;
         e_d.rt   = rt_d;
      end
      m_d      = e_q;
      m_d.tnew = dec(e_q.tnew);
      w_d.a3   = m_q.a3;
      w_d.we   = m_q.we;
      w_d.tnew = dec(m_q.tnew);
      if (!stall && md_start_d)
         cnt_d = md_div_d ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
      else if (cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
      else
         cnt_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_q   <= '0;
         m_q   <= '0;
         w_q   <= '0;
         cnt_q <= '0;
      end else begin
         e_q   <= e_d;
         m_q   <= m_d;
         w_q   <= w_d;
         cnt_q <= cnt_d;
      end
   end

endmodule
